// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one iteration per clock).
// Drives per-digit display decoders with a bounded digit count, overflow flag and leading-zero mask.
module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow,
  output logic [DIGITS-1:0]   nz_mask
);

  localparam int FULL_DIGITS = (3 * BIN_W) / 10 + 1;
  localparam int ACC_W       = 4 * FULL_DIGITS;
  localparam int CNT_W       = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   nz_q, nz_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_shift;
  logic [BIN_W-1:0]    shift_shift;
  logic [DIGITS-1:0]   dig_nz;
  logic [DIGITS-1:0]   final_nz;
  logic                final_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < FULL_DIGITS; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                             : acc_q[4*gi +: 4];
    end
  endgenerate

  assign acc_shift   = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
  assign shift_shift = {shift_q[BIN_W-2:0], 1'b0};

  // Digits beyond the displayed range only feed the overflow flag.
  generate
    if (FULL_DIGITS > DIGITS) begin : g_ovf
      assign final_ovf = |acc_shift[ACC_W-1:4*DIGITS];
    end else begin : g_no_ovf
      assign final_ovf = 1'b0;
    end
    for (gi = 0; gi < DIGITS; gi++) begin : g_nz
      assign dig_nz[gi]   = |acc_shift[4*gi +: 4];
      assign final_nz[gi] = final_ovf | (gi == 0) | (|dig_nz[DIGITS-1:gi]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    nz_d    = nz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_shift;
        acc_d   = acc_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          bcd_d   = acc_shift[4*DIGITS-1:0];
          ovf_d   = final_ovf;
          nz_d    = final_nz;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      nz_q    <= DIGITS'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      nz_q    <= nz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign nz_mask  = nz_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: vector table plus multi-cycle handshake sequences.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        overflow;
  logic [5:0]  nz_mask;

  int tests = 0;
  int fails = 0;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(6)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .nz_mask(nz_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] b;
    logic [23:0] exp_bcd;
    logic        exp_ovf;
    logic [5:0]  exp_nz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", nm, act);
    end
  endtask

  // Called at the negedge following the accepting edge; returns cycles to done (-1 on timeout).
  task automatic wait_done(input int k0, output int lat, output int busy_bad);
    int k;
    k = k0;
    busy_bad = 0;
    while (!done && k < 200) begin
      if (!busy) busy_bad++;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    lat = done ? k : -1;
  endtask

  task automatic accept(input logic [31:0] b);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = $urandom;
  endtask

  vec_t vecs[9];
  int   lat, bb, ndone, last_i;

  initial begin
    vecs[0] = '{32'd0,          24'h000000, 1'b0, 6'b000001};
    vecs[1] = '{32'd23,         24'h000023, 1'b0, 6'b000011};
    vecs[2] = '{32'd999999,     24'h999999, 1'b0, 6'b111111};
    vecs[3] = '{32'd1000000,    24'h000000, 1'b1, 6'b111111};
    vecs[4] = '{32'hFFFFFFFF,   24'h967295, 1'b1, 6'b111111};
    vecs[5] = '{32'd100,        24'h000100, 1'b0, 6'b000111};
    vecs[6] = '{32'd10,         24'h000010, 1'b0, 6'b000011};
    vecs[7] = '{32'd100000,     24'h100000, 1'b0, 6'b111111};
    vecs[8] = '{32'd5,          24'h000005, 1'b0, 6'b000001};

    reset = 1'b1;
    start = 1'b1;
    bin   = 32'd12345;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {8'd0, bcd}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_nz", {26'd0, nz_mask}, 32'd1);

    foreach (vecs[i]) begin
      accept(vecs[i].b);
      wait_done(0, lat, bb);
      chk($sformatf("v%0d_latency", i), lat, 32'd32);
      chk($sformatf("v%0d_busy_run", i), bb, 32'd0);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_bcd", i), {8'd0, bcd}, {8'd0, vecs[i].exp_bcd});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_nz", i), {26'd0, nz_mask}, {26'd0, vecs[i].exp_nz});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_hold_bcd", i), {8'd0, bcd}, {8'd0, vecs[i].exp_bcd});
    end

    // start while busy is ignored; start in the done cycle is accepted
    accept(32'd1234);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b1;
    bin   = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("mid_hold_bcd", {8'd0, bcd}, 32'h5);
    wait_done(10, lat, bb);
    chk("ign_latency", lat, 32'd32);
    chk("ign_bcd", {8'd0, bcd}, 32'h1234);
    chk("ign_nz", {26'd0, nz_mask}, 32'b001111);
    accept(32'd5);
    wait_done(0, lat, bb);
    chk("b2b_latency", lat, 32'd32);
    chk("b2b_bcd", {8'd0, bcd}, 32'h5);

    // reset mid-conversion aborts without done
    accept(32'd77);
    wait_done(0, lat, bb);
    chk("r77_bcd", {8'd0, bcd}, 32'h77);
    accept(32'd4321);
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd", {8'd0, bcd}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    chk("abort_nz", {26'd0, nz_mask}, 32'd1);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);

    // start held high: each conversion re-accepted in its done cycle
    start  = 1'b1;
    bin    = 32'd100;
    ndone  = 0;
    last_i = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        chk($sformatf("hold%0d_gap", ndone), i - last_i, 32'd33);
        chk($sformatf("hold%0d_bcd", ndone), {8'd0, bcd}, 32'h100);
        chk($sformatf("hold%0d_nz", ndone), {26'd0, nz_mask}, 32'b000111);
        last_i = i;
      end
    end
    start = 1'b0;
    chk("hold_count", ndone, 32'd3);
    wait_done(0, lat, bb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
